// File: rtl/ioctl_loader_ctrl.sv
// Download loader: turns the host byte stream (ioctl_*) into handshaked RAM
// writes, strips and parses the 7800 cart header, and reports cart metadata.
module ioctl_loader_ctrl #(
    parameter int unsigned HDR_LEN = 128,
    parameter int unsigned BIOS_AW = 12,
    parameter int unsigned CART_AW = 18
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ioctl_download,
    input  logic [7:0]         ioctl_index,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    output logic               ioctl_wait,
    output logic               mem_req,
    input  logic               mem_ack,
    output logic               mem_sel,
    output logic [CART_AW-1:0] mem_addr,
    output logic [7:0]         mem_data,
    output logic               cart_is_7800,
    output logic [31:0]        cart_size,
    output logic [15:0]        cart_flags,
    output logic [7:0]         joy0_type,
    output logic [7:0]         joy1_type,
    output logic [7:0]         cart_region,
    output logic [7:0]         cart_save,
    output logic               run_pause,
    output logic               busy
);

    localparam int unsigned         IOCTL_AW  = 25;
    localparam logic [IOCTL_AW-1:0] HDR_LEN_A = IOCTL_AW'(HDR_LEN);
    localparam logic [31:0]         HDR_LEN_W = 32'(HDR_LEN);
    localparam logic [39:0]         MAGIC     = 40'h41_54_41_52_49; // "ATARI"

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 is_cart_q, is_cart_d;
    logic                 req_q, req_d;
    logic                 sel_q, sel_d;
    logic [CART_AW-1:0]   addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic                 is7800_q, is7800_d;
    logic [3:0]           hit_q, hit_d;
    logic [15:0]          flags_q, flags_d;
    logic [7:0]           joy0_q, joy0_d;
    logic [7:0]           joy1_q, joy1_d;
    logic [7:0]           region_q, region_d;
    logic [7:0]           save_q, save_d;
    logic [31:0]          size_q, size_d;
    logic                 run_pause_q, run_pause_d;
    logic                 seen_q, seen_d;
    logic [IOCTL_AW-1:0]  last_q, last_d;
    logic                 busy_q;

    logic [IOCTL_AW-1:0]  mapped_c;
    logic                 drop_c;
    logic [31:0]          end_c;
    logic [31:0]          off_c;

    // Address mapping for the current strobe and out-of-range drop decision
    always_comb begin
        mapped_c = (is7800_q && (ioctl_addr >= HDR_LEN_A)) ? (ioctl_addr - HDR_LEN_A) : ioctl_addr;
        if (is_cart_q) begin
            drop_c = (mapped_c >> CART_AW) != '0;
        end else begin
            drop_c = (ioctl_addr >> BIOS_AW) != '0;
        end
        end_c = 32'(last_q) + 32'd1;
        off_c = is7800_q ? HDR_LEN_W : 32'd0;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        is_cart_d   = is_cart_q;
        req_d       = req_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        data_d      = data_q;
        is7800_d    = is7800_q;
        hit_d       = hit_q;
        flags_d     = flags_q;
        joy0_d      = joy0_q;
        joy1_d      = joy1_q;
        region_d    = region_q;
        save_d      = save_q;
        size_d      = size_q;
        run_pause_d = run_pause_q;
        seen_d      = seen_q;
        last_d      = last_q;

        case (state_q)
            S_IDLE: begin
                if (ioctl_download) begin
                    state_d   = S_LOAD;
                    is_cart_d = ioctl_index != 8'd0;
                    seen_d    = 1'b0;
                    last_d    = '0;
                    if (ioctl_index != 8'd0) begin
                        is7800_d = 1'b0;
                        hit_d    = '0;
                        flags_d  = '0;
                        joy0_d   = '0;
                        joy1_d   = '0;
                        region_d = '0;
                        save_d   = '0;
                    end
                end
            end
            S_LOAD: begin
                if (!ioctl_download) begin
                    state_d = S_FINISH;
                end else if (ioctl_wr) begin
                    seen_d = 1'b1;
                    last_d = ioctl_addr;
                    if (is_cart_q) begin
                        case (ioctl_addr)
                            25'd1:   hit_d[0] = ioctl_dout == MAGIC[39:32];
                            25'd2:   hit_d[1] = ioctl_dout == MAGIC[31:24];
                            25'd3:   hit_d[2] = ioctl_dout == MAGIC[23:16];
                            25'd4:   hit_d[3] = ioctl_dout == MAGIC[15:8];
                            25'd5:   is7800_d = (&hit_q) && (ioctl_dout == MAGIC[7:0]);
                            25'd53:  flags_d[15:8] = ioctl_dout;
                            25'd54:  flags_d[7:0]  = ioctl_dout;
                            25'd55:  joy0_d   = ioctl_dout;
                            25'd56:  joy1_d   = ioctl_dout;
                            25'd57:  region_d = ioctl_dout;
                            25'd58:  save_d   = ioctl_dout;
                            default: ;
                        endcase
                    end
                    if (!drop_c) begin
                        state_d = S_WRITE;
                        req_d   = 1'b1;
                        sel_d   = is_cart_q;
                        addr_d  = is_cart_q ? mapped_c[CART_AW-1:0]
                                            : CART_AW'(ioctl_addr[BIOS_AW-1:0]);
                        data_d  = ioctl_dout;
                    end
                end
            end
            S_WRITE: begin
                // strobes are ignored here; only the ack moves us on
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = ioctl_download ? S_LOAD : S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                if (is_cart_q) begin
                    size_d      = (!seen_q || (end_c < off_c)) ? 32'd0 : (end_c - off_c);
                    run_pause_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            is_cart_q   <= 1'b0;
            req_q       <= 1'b0;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            is7800_q    <= 1'b0;
            hit_q       <= '0;
            flags_q     <= '0;
            joy0_q      <= '0;
            joy1_q      <= '0;
            region_q    <= '0;
            save_q      <= '0;
            size_q      <= '0;
            run_pause_q <= 1'b1;
            seen_q      <= 1'b0;
            last_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_cart_q   <= is_cart_d;
            req_q       <= req_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            is7800_q    <= is7800_d;
            hit_q       <= hit_d;
            flags_q     <= flags_d;
            joy0_q      <= joy0_d;
            joy1_q      <= joy1_d;
            region_q    <= region_d;
            save_q      <= save_d;
            size_q      <= size_d;
            run_pause_q <= run_pause_d;
            seen_q      <= seen_d;
            last_q      <= last_d;
            busy_q      <= state_d != S_IDLE;
        end
    end

    assign ioctl_wait   = req_q;
    assign mem_req      = req_q;
    assign mem_sel      = sel_q;
    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign cart_is_7800 = is7800_q;
    assign cart_size    = size_q;
    assign cart_flags   = flags_q;
    assign joy0_type    = joy0_q;
    assign joy1_type    = joy1_q;
    assign cart_region  = region_q;
    assign cart_save    = save_q;
    assign run_pause    = run_pause_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ioctl_loader_ctrl.sv
// Scoreboard bench for ioctl_loader_ctrl: a reference model predicts every RAM
// write and the cart metadata; a monitor pops and checks writes as they appear.
module tb_ioctl_loader_ctrl;

    localparam int unsigned HDR_LEN = 128;
    localparam int unsigned BIOS_AW = 12;
    localparam int unsigned CART_AW = 18;

    logic               clk_sys;
    logic               reset_n;
    logic               ioctl_download;
    logic [7:0]         ioctl_index;
    logic               ioctl_wr;
    logic [24:0]        ioctl_addr;
    logic [7:0]         ioctl_dout;
    logic               ioctl_wait;
    logic               mem_req;
    logic               mem_ack;
    logic               mem_sel;
    logic [CART_AW-1:0] mem_addr;
    logic [7:0]         mem_data;
    logic               cart_is_7800;
    logic [31:0]        cart_size;
    logic [15:0]        cart_flags;
    logic [7:0]         joy0_type, joy1_type, cart_region, cart_save;
    logic               run_pause;
    logic               busy;

    ioctl_loader_ctrl #(.HDR_LEN(HDR_LEN), .BIOS_AW(BIOS_AW), .CART_AW(CART_AW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_data(mem_data),
        .cart_is_7800(cart_is_7800), .cart_size(cart_size), .cart_flags(cart_flags),
        .joy0_type(joy0_type), .joy1_type(joy1_type), .cart_region(cart_region),
        .cart_save(cart_save), .run_pause(run_pause), .busy(busy)
    );

    typedef struct {
        logic               sel;
        logic [CART_AW-1:0] addr;
        logic [7:0]         data;
        int                 wlen;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_delay = 0;

    // reference model state
    bit                  m_cart;
    bit                  m_7800;
    bit                  m_seen;
    bit                  m_run_pause;
    int unsigned         m_last;
    logic [31:0]         m_size;
    logic [15:0]         m_flags;
    logic [7:0]          m_joy0, m_joy1, m_region, m_save;
    logic [7:0]          hdr [int unsigned];
    logic [7:0]          magic [5] = '{8'h41, 8'h54, 8'h41, 8'h52, 8'h49};

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // RAM model: acks each request ack_delay cycles after mem_req rises
    initial begin : responder
        int ack_cnt;
        ack_cnt = 0;
        mem_ack = 1'b0;
        forever begin
            @(posedge clk_sys); #1;
            mem_ack = 1'b0;
            if (mem_req && reset_n) begin
                if (ack_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    ack_cnt = 0;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    // Monitor: pops one expectation per write, checks payload, stability and wait length
    initial begin : monitor
        exp_t               e;
        bit                 in_wr;
        bit                 have_e;
        bit                 stable;
        int                 wlen;
        logic [CART_AW-1:0] a0;
        logic [7:0]         d0;
        logic               s0;
        in_wr = 0;
        have_e = 0;
        stable = 1;
        wlen = 0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                in_wr = 0;
                continue;
            end
            if (mem_req && !in_wr) begin
                in_wr = 1;
                wlen = 0;
                stable = 1;
                a0 = mem_addr;
                d0 = mem_data;
                s0 = mem_sel;
                if (sb.size() == 0) begin
                    have_e = 0;
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", mem_addr, mem_data);
                end else begin
                    have_e = 1;
                    e = sb.pop_front();
                    chk("mem_sel", 32'(mem_sel), 32'(e.sel));
                    chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                    chk("mem_data", 32'(mem_data), 32'(e.data));
                end
            end
            if (in_wr) begin
                if (mem_req) begin
                    if (ioctl_wait) wlen++;
                    if (mem_addr !== a0 || mem_data !== d0 || mem_sel !== s0 || ioctl_wait !== 1'b1)
                        stable = 0;
                end else begin
                    in_wr = 0;
                    chk("write_stable", 32'(stable), 32'd1);
                    if (have_e) chk("wait_len", 32'(wlen), 32'(e.wlen));
                end
            end
        end
    end

    task automatic model_reset();
        m_7800 = 0; m_size = '0; m_flags = '0; m_joy0 = '0; m_joy1 = '0;
        m_region = '0; m_save = '0; m_run_pause = 1; m_seen = 0; m_last = 0;
    endtask

    task automatic model_start(input logic [7:0] idx);
        m_cart = idx != 8'd0;
        m_seen = 0;
        m_last = 0;
        if (m_cart) begin
            hdr.delete();
            m_7800 = 0; m_flags = '0; m_joy0 = '0; m_joy1 = '0; m_region = '0; m_save = '0;
        end
    endtask

    // Predict the effect of one host byte; pushes the expected write if not dropped
    task automatic model_byte(input logic [24:0] a, input logic [7:0] d, input int dly);
        int unsigned ua;
        int unsigned mapped;
        bit          wr;
        bit          ok;
        exp_t        e;
        ua = 32'(a);
        if (m_cart) begin
            mapped = (m_7800 && ua >= HDR_LEN) ? ua - HDR_LEN : ua;
            wr = mapped < (32'd1 << CART_AW);
            m_seen = 1;
            m_last = ua;
            if (ua < 64) hdr[ua] = d;
            if (ua == 5) begin
                ok = 1;
                for (int unsigned i = 1; i <= 5; i++)
                    if (!hdr.exists(i) || hdr[i] != magic[i-1]) ok = 0;
                m_7800 = ok;
            end
            if (ua == 53) m_flags[15:8] = d;
            if (ua == 54) m_flags[7:0] = d;
            if (ua == 55) m_joy0 = d;
            if (ua == 56) m_joy1 = d;
            if (ua == 57) m_region = d;
            if (ua == 58) m_save = d;
        end else begin
            mapped = ua;
            wr = ua < (32'd1 << BIOS_AW);
        end
        if (wr) begin
            e.sel = m_cart;
            e.addr = CART_AW'(mapped);
            e.data = d;
            e.wlen = dly + 1;
            sb.push_back(e);
        end
    endtask

    task automatic check_finals(input string tag);
        chk({tag, "_cart_size"}, cart_size, m_size);
        chk({tag, "_is_7800"}, 32'(cart_is_7800), 32'(m_7800));
        chk({tag, "_flags"}, 32'(cart_flags), 32'(m_flags));
        chk({tag, "_joy0"}, 32'(joy0_type), 32'(m_joy0));
        chk({tag, "_joy1"}, 32'(joy1_type), 32'(m_joy1));
        chk({tag, "_region"}, 32'(cart_region), 32'(m_region));
        chk({tag, "_save"}, 32'(cart_save), 32'(m_save));
        chk({tag, "_run_pause"}, 32'(run_pause), 32'(m_run_pause));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_ioctl_wait"}, 32'(ioctl_wait), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_data"}, 32'(mem_data), 32'd0);
        chk({tag, "_mem_sel"}, 32'(mem_sel), 32'd0);
        check_finals(tag);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(posedge clk_sys); #1;
        ioctl_index = idx;
        ioctl_download = 1'b1;
        model_start(idx);
    endtask

    // One host byte; optionally drops the download or pokes a stray strobe mid-write
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int dly,
                             input bit drop_dl, input bit poke);
        int i;
        model_byte(a, d, dly);
        ack_delay = dly;
        @(posedge clk_sys); #1;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        if (drop_dl) ioctl_download = 1'b0;
        if (poke) begin
            @(posedge clk_sys); #1;
            ioctl_addr = 25'h3FF;
            ioctl_dout = 8'hEE;
            ioctl_wr = 1'b1;
            @(posedge clk_sys); #1;
            ioctl_wr = 1'b0;
        end
        for (i = 0; i < 64; i++) begin
            if (!ioctl_wait) break;
            @(posedge clk_sys); #1;
        end
        if (i == 64) fail_now("wait_timeout");
    endtask

    task automatic end_dl();
        int i;
        int unsigned off;
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        for (i = 0; i < 32; i++) begin
            @(posedge clk_sys); #1;
            if (!busy) break;
        end
        if (i == 32) fail_now("busy_timeout");
        if (m_cart) begin
            off = m_7800 ? HDR_LEN : 0;
            m_size = (!m_seen || (m_last + 1 < off)) ? 32'd0 : 32'(m_last + 1 - off);
            m_run_pause = 0;
        end
        check_finals("end");
    endtask

    function automatic logic [7:0] b7800(input int unsigned a);
        logic [7:0] v;
        v = 8'($urandom);
        if (a >= 1 && a <= 5) v = magic[a-1];
        if (a == 53) v = 8'h12;
        if (a == 54) v = 8'h34;
        if (a == 57) v = 8'h01;
        return v;
    endfunction

    initial begin : stim
        logic [7:0] d;
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        m_cart = 0;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        check_reset("por");
        reset_n = 1'b1;

        // BIOS: three bytes plus one out-of-range byte that must be dropped
        start_dl(8'd0);
        send_byte(25'd0, 8'hA9, 0, 0, 0);
        send_byte(25'd1, 8'h00, 0, 0, 0);
        send_byte(25'd2, 8'h8D, 0, 0, 0);
        send_byte(25'h1000, 8'h55, 0, 0, 0);
        end_dl();
        chk("bios_cart_size", cart_size, 32'd0);
        chk("bios_run_pause", 32'(run_pause), 32'd1);

        // 7800 cart, 256 bytes
        start_dl(8'd1);
        for (int unsigned a = 0; a < 256; a++)
            send_byte(25'(a), b7800(a), int'($urandom_range(0, 3)), 0, 0);
        end_dl();
        chk("a78_is_7800", 32'(cart_is_7800), 32'd1);
        chk("a78_flags", 32'(cart_flags), 32'h1234);
        chk("a78_region", 32'(cart_region), 32'h01);
        chk("a78_size", cart_size, 32'd128);
        chk("a78_run_pause", 32'(run_pause), 32'd0);

        // raw cart, 4096 bytes, no signature
        start_dl(8'd2);
        for (int unsigned a = 0; a < 4096; a++) begin
            d = 8'($urandom);
            if (a == 1) d = 8'h00;
            send_byte(25'(a), d, int'($urandom_range(0, 2)), 0, 0);
        end
        end_dl();
        chk("raw_is_7800", 32'(cart_is_7800), 32'd0);
        chk("raw_size", cart_size, 32'd4096);

        // slow RAM, stray strobe during a write, download drops mid-write
        start_dl(8'd3);
        for (int unsigned a = 0; a < 8; a++)
            send_byte(25'(a), 8'($urandom), 5, a == 7, a == 3);
        end_dl();
        chk("fall_size", cart_size, 32'd8);

        // BIOS after a cart leaves cart metadata alone
        start_dl(8'd0);
        for (int i = 0; i < 4; i++)
            send_byte(25'($urandom_range(0, 4095)), 8'($urandom), int'($urandom_range(0, 3)), 0, 0);
        end_dl();

        // reset while a write is outstanding
        start_dl(8'd5);
        send_byte(25'd0, 8'h11, 0, 0, 0);
        model_byte(25'd1, 8'h22, 30);
        ack_delay = 30;
        @(posedge clk_sys); #1;
        ioctl_addr = 25'd1;
        ioctl_dout = 8'h22;
        ioctl_wr = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        chk("req_in_write", 32'(mem_req), 32'd1);
        @(posedge clk_sys); #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset("rst_in_write");
        ack_delay = 0;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        model_start(8'd5);
        @(posedge clk_sys); #1;
        chk("load_after_rst", 32'(busy), 32'd1);
        for (int unsigned a = 0; a < 3; a++)
            send_byte(25'(a), 8'($urandom), int'($urandom_range(0, 3)), 0, 0);
        end_dl();
        chk("post_rst_size", cart_size, 32'd3);

        repeat (5) @(posedge clk_sys);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
